// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus between a requester
// and the sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic              start;
    logic              is_signed;
    logic [WIDTH-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic              neg;
    logic [4*DIGITS-1:0] bcd_out;

    modport master (
        output start,
        output is_signed,
        output bin_in,
        input  busy,
        input  done,
        input  neg,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  is_signed,
        input  bin_in,
        output busy,
        output done,
        output neg,
        output bcd_out
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per cycle, signed or
// unsigned input, result and sign held until the next completion.
module bin2bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    bin2bcd_seq_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]   scr_q, scr_d;
    logic            neg_r_q, neg_r_d;
    logic            neg_q, neg_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            done_q, done_d;
    logic [BW-1:0]   adj;

    // Add-3 correction on every digit before the shift
    always_comb begin
        adj = scr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        neg_r_d = neg_r_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.is_signed && bus.bin_in[WIDTH-1])
                        bin_d = ~bus.bin_in + {{(WIDTH-1){1'b0}}, 1'b1};
                    else
                        bin_d = bus.bin_in;
                    neg_r_d = bus.is_signed & bus.bin_in[WIDTH-1];
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                {scr_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST)
                    state_d = S_DONE;
            end
            S_DONE: begin
                bcd_d   = scr_q;
                neg_d   = neg_r_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset is active-high despite the port name
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            neg_r_q <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            neg_r_q <= neg_r_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.neg     = neg_q;
    assign bus.bcd_out = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, signed/unsigned results,
// ignored starts, reset abort and back-to-back throughput.
module tb_bin2bcd_seq;
    logic sys_clk;
    logic sys_rst_n;
    int   total;
    int   bad;

    bin2bcd_seq_if #(.WIDTH(32), .DIGITS(10)) bif ();

    bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bif.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Drive one request; lat = cycles from accept edge to done, -1 on timeout
    task automatic convert(input logic [31:0] v, input logic s,
                           output int lat);
        bif.start     = 1'b1;
        bif.bin_in    = v;
        bif.is_signed = s;
        @(posedge sys_clk); #1;
        bif.start     = 1'b0;
        bif.bin_in    = 32'hDEADBEEF;
        bif.is_signed = ~s;
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge sys_clk); #1;
            if (bif.done) lat = i;
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        bif.start = 1'b0;
        bif.is_signed = 1'b0;
        bif.bin_in = '0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        repeat (5) @(posedge sys_clk);
        #1;
        total++;
        if (bif.busy !== 1'b0) begin
            bad++; $display("FAIL rst_busy got=%b exp=0", bif.busy);
        end
        total++;
        if (bif.done !== 1'b0) begin
            bad++; $display("FAIL rst_done got=%b exp=0", bif.done);
        end
        total++;
        if (bif.neg !== 1'b0) begin
            bad++; $display("FAIL rst_neg got=%b exp=0", bif.neg);
        end
        total++;
        if (bif.bcd_out !== 40'h0) begin
            bad++; $display("FAIL rst_bcd got=%h exp=0", bif.bcd_out);
        end
    endtask

    task automatic test_unsigned_max();
        int lat;
        bif.start = 1'b1;
        bif.bin_in = 32'hFFFFFFFF;
        bif.is_signed = 1'b0;
        @(posedge sys_clk); #1;
        bif.start = 1'b0;
        total++;
        if (bif.busy !== 1'b1) begin
            bad++; $display("FAIL umax_busy got=%b exp=1", bif.busy);
        end
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge sys_clk); #1;
            if (bif.done) lat = i;
        end
        total++;
        if (lat !== 33) begin
            bad++; $display("FAIL umax_lat got=%0d exp=33", lat);
        end
        total++;
        if (bif.bcd_out !== 40'h4294967295) begin
            bad++; $display("FAIL umax_bcd got=%h exp=4294967295", bif.bcd_out);
        end
        total++;
        if (bif.neg !== 1'b0) begin
            bad++; $display("FAIL umax_neg got=%b exp=0", bif.neg);
        end
        total++;
        if (bif.busy !== 1'b0) begin
            bad++; $display("FAIL umax_busy_done got=%b exp=0", bif.busy);
        end
        @(posedge sys_clk); #1;
        total++;
        if (bif.done !== 1'b0) begin
            bad++; $display("FAIL umax_pulse got=%b exp=0", bif.done);
        end
        total++;
        if (bif.bcd_out !== 40'h4294967295) begin
            bad++; $display("FAIL umax_hold got=%h exp=4294967295", bif.bcd_out);
        end
    endtask

    task automatic test_signed();
        logic [31:0] vin [4];
        logic        sin [4];
        logic [39:0] ebcd [4];
        logic        eneg [4];
        int lat;
        vin[0] = 32'hFFFFFFFF; sin[0] = 1; ebcd[0] = 40'h0000000001; eneg[0] = 1;
        vin[1] = 32'h80000000; sin[1] = 1; ebcd[1] = 40'h2147483648; eneg[1] = 1;
        vin[2] = 32'd1234;     sin[2] = 1; ebcd[2] = 40'h0000001234; eneg[2] = 0;
        vin[3] = 32'd0;        sin[3] = 1; ebcd[3] = 40'h0000000000; eneg[3] = 0;
        for (int k = 0; k < 4; k++) begin
            convert(vin[k], sin[k], lat);
            total++;
            if (lat !== 33) begin
                bad++; $display("FAIL sgn%0d_lat got=%0d exp=33", k, lat);
            end
            total++;
            if (bif.bcd_out !== ebcd[k]) begin
                bad++;
                $display("FAIL sgn%0d_bcd got=%h exp=%h", k, bif.bcd_out, ebcd[k]);
            end
            total++;
            if (bif.neg !== eneg[k]) begin
                bad++;
                $display("FAIL sgn%0d_neg got=%b exp=%b", k, bif.neg, eneg[k]);
            end
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        bif.start = 1'b1;
        bif.bin_in = 32'd99;
        bif.is_signed = 1'b0;
        @(posedge sys_clk); #1;
        bif.start = 1'b0;
        dones = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 10) begin
                bif.start = 1'b1;
                bif.bin_in = 32'd55;
            end else begin
                bif.start = 1'b0;
            end
            @(posedge sys_clk); #1;
            if (bif.done) dones++;
        end
        total++;
        if (dones !== 1) begin
            bad++; $display("FAIL ign_dones got=%0d exp=1", dones);
        end
        total++;
        if (bif.bcd_out !== 40'h99) begin
            bad++; $display("FAIL ign_bcd got=%h exp=99", bif.bcd_out);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        bif.start = 1'b1;
        bif.bin_in = 32'd777;
        bif.is_signed = 1'b0;
        @(posedge sys_clk); #1;
        bif.start = 1'b0;
        repeat (14) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        total++;
        if (bif.bcd_out !== 40'h0 || bif.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_clr got bcd=%h busy=%b exp 0/0",
                     bif.bcd_out, bif.busy);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge sys_clk); #1;
            if (bif.done) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++; $display("FAIL abort_dones got=%0d exp=0", dones);
        end
        total++;
        if (bif.bcd_out !== 40'h0 || bif.neg !== 1'b0 || bif.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_out got bcd=%h neg=%b busy=%b exp 0",
                     bif.bcd_out, bif.neg, bif.busy);
        end
    endtask

    task automatic test_after_abort();
        int lat;
        convert(32'd42, 1'b0, lat);
        total++;
        if (lat !== 33) begin
            bad++; $display("FAIL post_lat got=%0d exp=33", lat);
        end
        total++;
        if (bif.bcd_out !== 40'h42) begin
            bad++; $display("FAIL post_bcd got=%h exp=42", bif.bcd_out);
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic test_back_to_back();
        int gap;
        int lat;
        bif.start = 1'b1;
        bif.bin_in = 32'd12345678;
        bif.is_signed = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge sys_clk); #1;
            if (bif.done) lat = i;
        end
        total++;
        if (bif.bcd_out !== 40'h0012345678) begin
            bad++; $display("FAIL b2b_a got=%h exp=0012345678", bif.bcd_out);
        end
        bif.bin_in = 32'd87654321;
        gap = -1;
        for (int i = 1; i <= 40 && gap < 0; i++) begin
            @(posedge sys_clk); #1;
            if (bif.done) gap = i;
        end
        bif.start = 1'b0;
        total++;
        if (gap !== 34) begin
            bad++; $display("FAIL b2b_gap got=%0d exp=34", gap);
        end
        total++;
        if (bif.bcd_out !== 40'h0087654321) begin
            bad++; $display("FAIL b2b_b got=%h exp=0087654321", bif.bcd_out);
        end
        repeat (40) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_ignore_start();
        test_reset_abort();
        test_after_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
